module_bcd_display_driver: RTL and testbench

MODULE_BCD_DISPLAY_DRIVER -- requirements
Module: module_bcd_display_driver

---
 rtl/module_bcd_display_driver.sv | 171 +++++++++++++++++
 tb/tb_module_bcd_display_driver.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/module_bcd_display_driver.sv
// Binary-to-BCD converter (double dabble) feeding a multiplexed 7-seg display.
// Ports: clk, rst (sync, active-high), load/bin in; busy, done, seg, an out.
module module_bcd_display_driver #(
  parameter int WIDTH       = 12,
  parameter int DIGITS      = 4,
  parameter int REFRESH_DIV = 27000,
  parameter int LZ_BLANK    = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [WIDTH-1:0]  bin,
  output logic              busy,
  output logic              done,
  output logic [6:0]        seg,
  output logic [DIGITS-1:0] an
);

  // BCD register holds every decimal digit WIDTH bits can produce,
  // and at least DIGITS digits so narrow inputs still fill the display.
  localparam int NB   = (WIDTH * 3) / 10 + 1;
  localparam int NBCD = (NB > DIGITS) ? NB : DIGITS;
  localparam int BW   = 4 * NBCD;
  localparam int CW   = $clog2(WIDTH + 1);
  localparam int RW   = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int DW   = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_SHIFT,
    S_COMMIT
  } state_t;

  state_t              r_state;
  state_t              w_next;
  logic [WIDTH-1:0]    r_bin;
  logic [BW-1:0]       r_bcd;
  logic [CW-1:0]       r_cnt;
  logic [4*DIGITS-1:0] r_disp;
  logic                r_ovf;
  logic                r_done;
  logic [BW-1:0]       w_adj;
  logic                w_ovf;

  logic [RW-1:0]       r_ref;
  logic [DW-1:0]       r_dig;
  logic [DIGITS-1:0]   r_an;
  logic [6:0]          r_seg;
  logic [DIGITS-1:0]   w_show;
  logic [3:0]          w_nib;
  logic [6:0]          w_seg;

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:   if (load) w_next = S_SHIFT;
      S_SHIFT:  if (r_cnt == CW'(WIDTH - 1)) w_next = S_COMMIT;
      S_COMMIT: w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  // Add-3 correction on every nibble before the shift.
  always_comb begin
    w_adj = r_bcd;
    for (int i = 0; i < NBCD; i++) begin
      if (r_bcd[4*i +: 4] >= 4'd5)
        w_adj[4*i +: 4] = r_bcd[4*i +: 4] + 4'd3;
    end
  end

  // Any nonzero digit above the display width means overflow.
  always_comb begin
    w_ovf = 1'b0;
    for (int i = DIGITS; i < NBCD; i++) begin
      w_ovf = w_ovf | (|r_bcd[4*i +: 4]);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_bin   <= '0;
      r_bcd   <= '0;
      r_cnt   <= '0;
      r_disp  <= '0;
      r_ovf   <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_next;
      r_done  <= 1'b0;
      if (r_state == S_IDLE) begin
        if (load) begin
          r_bin <= bin;
          r_bcd <= '0;
          r_cnt <= '0;
        end
      end else if (r_state == S_SHIFT) begin
        r_bcd <= {w_adj[BW-2:0], r_bin[WIDTH-1]};
        r_bin <= {r_bin[WIDTH-2:0], 1'b0};
        r_cnt <= r_cnt + 1'b1;
      end else begin
        r_disp <= r_bcd[4*DIGITS-1:0];
        r_ovf  <= w_ovf;
        r_done <= 1'b1;
      end
    end
  end

  // A digit is shown if it or any higher digit is nonzero;
  // digit 0 is always shown.
  always_comb begin
    logic v_acc;
    v_acc  = 1'b0;
    w_show = '0;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      v_acc     = v_acc | (r_disp[4*i +: 4] != 4'd0);
      w_show[i] = v_acc || (i == 0) || (LZ_BLANK == 0);
    end
  end

  assign w_nib = r_disp[4*int'(r_dig) +: 4];

  always_comb begin
    w_seg = 7'b0000000;
    if (r_ovf) begin
      w_seg = 7'b1000000;
    end else if (w_show[r_dig]) begin
      case (w_nib)
        4'd0:    w_seg = 7'b0111111;
        4'd1:    w_seg = 7'b0000110;
        4'd2:    w_seg = 7'b1011011;
        4'd3:    w_seg = 7'b1001111;
        4'd4:    w_seg = 7'b1100110;
        4'd5:    w_seg = 7'b1101101;
        4'd6:    w_seg = 7'b1111101;
        4'd7:    w_seg = 7'b0000111;
        4'd8:    w_seg = 7'b1111111;
        4'd9:    w_seg = 7'b1101111;
        default: w_seg = 7'b0000000;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ref <= '0;
      r_dig <= '0;
      r_an  <= ~DIGITS'(1);
      r_seg <= 7'b0111111;
    end else begin
      if (r_ref == RW'(REFRESH_DIV - 1)) begin
        r_ref <= '0;
        if (r_dig == DW'(DIGITS - 1))
          r_dig <= '0;
        else
          r_dig <= r_dig + 1'b1;
      end else begin
        r_ref <= r_ref + 1'b1;
      end
      r_an  <= ~(DIGITS'(1) << r_dig);
      r_seg <= w_seg;
    end
  end

  assign busy = (r_state != S_IDLE);
  assign done = r_done;
  assign seg  = r_seg;
  assign an   = r_an;

endmodule

// File: tb/tb_module_bcd_display_driver.sv
// Directed bench for module_bcd_display_driver with a scan scoreboard.
// Three instances: default, leading zeros shown, and 3-digit display.
module tb_module_bcd_display_driver;

  logic        clk = 1'b0;
  logic        rst;
  logic        load;
  logic [11:0] bin;

  logic       busy_a, done_a, busy_b, done_b, busy_c, done_c;
  logic [6:0] seg_a, seg_b, seg_c;
  logic [3:0] an_a, an_b;
  logic [2:0] an_c;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct packed {
    logic [3:0] an;
    logic [6:0] seg;
  } pair_t;

  pair_t q[$];

  always #5 clk = ~clk;

  module_bcd_display_driver #(
    .WIDTH(12), .DIGITS(4), .REFRESH_DIV(4), .LZ_BLANK(1)
  ) u_a (
    .clk(clk), .rst(rst), .load(load), .bin(bin),
    .busy(busy_a), .done(done_a), .seg(seg_a), .an(an_a)
  );

  module_bcd_display_driver #(
    .WIDTH(12), .DIGITS(4), .REFRESH_DIV(4), .LZ_BLANK(0)
  ) u_b (
    .clk(clk), .rst(rst), .load(load), .bin(bin),
    .busy(busy_b), .done(done_b), .seg(seg_b), .an(an_b)
  );

  module_bcd_display_driver #(
    .WIDTH(12), .DIGITS(3), .REFRESH_DIV(4), .LZ_BLANK(1)
  ) u_c (
    .clk(clk), .rst(rst), .load(load), .bin(bin),
    .busy(busy_c), .done(done_c), .seg(seg_c), .an(an_c)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [6:0] code(input int d);
    case (d)
      0: return 7'b0111111;
      1: return 7'b0000110;
      2: return 7'b1011011;
      3: return 7'b1001111;
      4: return 7'b1100110;
      5: return 7'b1101101;
      6: return 7'b1111101;
      7: return 7'b0000111;
      8: return 7'b1111111;
      9: return 7'b1101111;
      default: return 7'b0000000;
    endcase
  endfunction

  function automatic logic [3:0] an_of(input int w);
    case (w)
      0: return an_a;
      1: return an_b;
      default: return {1'b1, an_c};
    endcase
  endfunction

  function automatic logic [6:0] seg_of(input int w);
    case (w)
      0: return seg_a;
      1: return seg_b;
      default: return seg_c;
    endcase
  endfunction

  task automatic push_exp(input int v, input int nd, input bit lz);
    int    lim;
    int    p;
    pair_t e;
    lim = 1;
    for (int i = 0; i < nd; i++) lim = lim * 10;
    p = 1;
    for (int i = 0; i < nd; i++) begin
      e.an = 4'hF & ~(4'b0001 << i);
      if (v > lim - 1)
        e.seg = 7'b1000000;
      else if (!lz || i == 0 || (v / p) != 0)
        e.seg = code((v / p) % 10);
      else
        e.seg = 7'b0000000;
      q.push_back(e);
      p = p * 10;
    end
  endtask

  task automatic scan_check(input int w, input int nd, input string tag);
    bit    found;
    pair_t e;
    found = 1'b0;
    for (int i = 0; i < 64 && !found; i++) begin
      @(negedge clk);
      if (an_of(w) == 4'b1110) found = 1'b1;
    end
    chk({tag, "_sync"}, 32'(found), 32'd1);
    for (int k = 0; k < nd; k++) begin
      e = q.pop_front();
      chk($sformatf("%s_an%0d", tag, k), 32'(an_of(w)), 32'(e.an));
      chk($sformatf("%s_seg%0d", tag, k), 32'(seg_of(w)), 32'(e.seg));
      repeat (4) @(negedge clk);
    end
  endtask

  task automatic do_load(input int v, input string tag);
    bit early;
    bit idle;
    early = 1'b0;
    idle  = 1'b0;
    @(negedge clk);
    load = 1'b1;
    bin  = 12'(v);
    @(negedge clk);
    load = 1'b0;
    chk({tag, "_busy"}, 32'(busy_a), 32'd1);
    for (int i = 1; i <= 12; i++) begin
      @(negedge clk);
      if (done_a) early = 1'b1;
      if (!busy_a) idle = 1'b1;
    end
    chk({tag, "_early_done"}, 32'(early), 32'd0);
    chk({tag, "_busy_held"}, 32'(idle), 32'd0);
    @(negedge clk);
    chk({tag, "_done"}, 32'(done_a), 32'd1);
    chk({tag, "_idle"}, 32'(busy_a), 32'd0);
    @(negedge clk);
    chk({tag, "_done_pulse"}, 32'(done_a), 32'd0);
  endtask

  initial begin
    int         dones;
    bit         moved;
    int         hold;
    logic [3:0] pat;
    logic [3:0] prev;

    rst  = 1'b1;
    load = 1'b0;
    bin  = '0;
    repeat (3) @(negedge clk);
    chk("rst_an", 32'(an_a), 32'b1110);
    chk("rst_seg", 32'(seg_a), 32'b0111111);
    chk("rst_busy", 32'(busy_a), 32'd0);
    chk("rst_done", 32'(done_a), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("rel_an", 32'(an_a), 32'b1110);
    chk("rel_seg", 32'(seg_a), 32'b0111111);
    push_exp(0, 4, 1'b1);
    scan_check(0, 4, "zero");

    do_load(1234, "l1234");
    push_exp(1234, 4, 1'b1);
    scan_check(0, 4, "v1234");

    do_load(7, "l7");
    push_exp(7, 4, 1'b1);
    push_exp(7, 4, 1'b0);
    scan_check(0, 4, "v7_lz1");
    scan_check(1, 4, "v7_lz0");

    do_load(1000, "l1000");
    push_exp(1000, 3, 1'b1);
    scan_check(2, 3, "v1000_d3");
    do_load(999, "l999");
    push_exp(999, 3, 1'b1);
    scan_check(2, 3, "v999_d3");

    @(negedge clk);
    load = 1'b1;
    bin  = 12'd42;
    @(negedge clk);
    load = 1'b0;
    push_exp(42, 4, 1'b1);
    dones = 0;
    repeat (4) begin
      @(negedge clk);
      if (done_a) dones++;
    end
    load = 1'b1;
    bin  = 12'd555;
    @(negedge clk);
    load = 1'b0;
    if (done_a) dones++;
    repeat (30) begin
      @(negedge clk);
      if (done_a) dones++;
    end
    chk("ign_done_cnt", 32'(dones), 32'd1);
    chk("ign_busy", 32'(busy_a), 32'd0);
    scan_check(0, 4, "v42");

    @(negedge clk);
    load = 1'b1;
    bin  = 12'd321;
    @(negedge clk);
    load = 1'b0;
    repeat (5) @(negedge clk);
    chk("abort_busy_pre", 32'(busy_a), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_busy", 32'(busy_a), 32'd0);
    chk("abort_done", 32'(done_a), 32'd0);
    dones = 0;
    repeat (20) begin
      @(negedge clk);
      if (done_a) dones++;
    end
    chk("abort_no_done", 32'(dones), 32'd0);
    push_exp(0, 4, 1'b1);
    scan_check(0, 4, "abort");

    moved = 1'b0;
    prev  = an_a;
    for (int i = 0; i < 40 && !moved; i++) begin
      @(negedge clk);
      if (an_a != prev) moved = 1'b1;
      prev = an_a;
    end
    chk("scan_edge", 32'(moved), 32'd1);
    for (int t = 0; t < 6; t++) begin
      pat  = an_a;
      hold = 1;
      for (int i = 0; i < 20; i++) begin
        @(negedge clk);
        if (an_a != pat) break;
        hold++;
      end
      chk($sformatf("scan_hold%0d", t), 32'(hold), 32'd4);
      chk($sformatf("scan_next%0d", t), 32'(an_a),
          32'((pat == 4'b0111) ? 4'b1110 : {pat[2:0], 1'b1}));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
